// File: rtl/sr_cmd_gen_pkg.sv
// Shared types and widths for the sr_cmd_gen set/reset command front-end.
// SR_CMD_GEN_DEBOUNCE_EN selects the debounce filter inside sr_cmd_debounce.
package sr_cmd_pkg;

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned DB_CNT_W = 8;
    localparam int unsigned GAP_W    = 4;

    typedef enum logic [1:0] {
        IDLE,
        SET_PULSE,
        CLR_PULSE,
        HOLDOFF
    } sr_cmd_state_t;

endpackage

// File: rtl/sr_cmd_gen_debounce.sv
// One request line: 2-flop synchroniser, optional debounce filter, rising-edge detect.
// Filter present only when SR_CMD_GEN_DEBOUNCE_EN is defined.
module sr_cmd_debounce
    import sr_cmd_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    output logic rise
);

    logic sync1_q, sync2_q;
    logic filt;
    logic prev_q;

`ifdef SR_CMD_GEN_DEBOUNCE_EN
    logic [DB_CNT_W-1:0] cnt_q, cnt_d;
    logic                filt_q, filt_d;

    // Counter saturates once accepted; any low sample drops the filter at once.
    always_comb begin
        cnt_d  = '0;
        filt_d = 1'b0;
        if (sync2_q) begin
            if (cnt_q >= DB_CNT_W'(DB_CYCLES - 1)) begin
                cnt_d  = cnt_q;
                filt_d = 1'b1;
            end else begin
                cnt_d = cnt_q + DB_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt = filt_q;
`else
    // DB_CYCLES has no effect without the filter.
    logic unused_db_cfg;
    assign unused_db_cfg = ^DB_CNT_W'(DB_CYCLES);
    assign filt          = sync2_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= req;
            sync2_q <= sync1_q;
            prev_q  <= filt;
        end
    end

    assign rise = filt & ~prev_q;

endmodule

// File: rtl/sr_cmd_gen.sv
// Turns raw set/clear request levels into exclusive one-cycle s/r pulses for an SR flop.
// Debounce filtering is enabled by defining SR_CMD_GEN_DEBOUNCE_EN.
module sr_cmd_gen
    import sr_cmd_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = 4,
    parameter int unsigned GAP_CYCLES = 2,
    parameter bit          PRIO_SET   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_req,
    input  logic             clr_req,
    output logic             s,
    output logic             r,
    output logic             busy,
    output logic             conflict,
    output logic [CNT_W-1:0] cmd_cnt
);

    logic set_rise, clr_rise;

    sr_cmd_debounce #(.DB_CYCLES(DB_CYCLES)) u_set_db (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (set_req),
        .rise  (set_rise)
    );

    sr_cmd_debounce #(.DB_CYCLES(DB_CYCLES)) u_clr_db (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (clr_req),
        .rise  (clr_rise)
    );

    sr_cmd_state_t    state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             pend_set_q, pend_set_d;
    logic             pend_clr_q, pend_clr_d;
    logic             s_q, s_d, r_q, r_d;
    logic             busy_q, busy_d;
    logic             conf_q, conf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             can_issue;
    logic             pick_set;

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        pend_set_d = pend_set_q | set_rise;
        pend_clr_d = pend_clr_q | clr_rise;
        s_d        = 1'b0;
        r_d        = 1'b0;
        conf_d     = 1'b0;
        cnt_d      = cnt_q;
        can_issue  = 1'b0;
        pick_set   = 1'b0;

        // The last HOLDOFF cycle arbitrates like IDLE so a request captured
        // during the gap issues right as the gap ends (spacing 1+GAP_CYCLES).
        case (state_q)
            IDLE: can_issue = 1'b1;
            SET_PULSE, CLR_PULSE: begin
                if (GAP_CYCLES == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLDOFF;
                    gap_d   = '0;
                end
            end
            HOLDOFF: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d   = IDLE;
                    can_issue = 1'b1;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (can_issue && (pend_set_d || pend_clr_d)) begin
            pick_set   = pend_set_d && (!pend_clr_d || PRIO_SET);
            conf_d     = pend_set_d && pend_clr_d;
            state_d    = pick_set ? SET_PULSE : CLR_PULSE;
            s_d        = pick_set;
            r_d        = !pick_set;
            cnt_d      = cnt_q + CNT_W'(1);
            pend_set_d = 1'b0;
            pend_clr_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gap_q      <= '0;
            pend_set_q <= 1'b0;
            pend_clr_q <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            conf_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            pend_set_q <= pend_set_d;
            pend_clr_q <= pend_clr_d;
            s_q        <= s_d;
            r_q        <= r_d;
            busy_q     <= busy_d;
            conf_q     <= conf_d;
            cnt_q      <= cnt_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign busy     = busy_q;
    assign conflict = conf_q;
    assign cmd_cnt  = cnt_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Self-checking bench for sr_cmd_gen: scenario table, corner sequences, random traffic vs. timeline model.
module tb_sr_cmd_gen;

    localparam int unsigned DB   = 4;
    localparam int unsigned GAP  = 2;
    localparam bit          PRIO = 1'b1;
`ifdef SR_CMD_GEN_DEBOUNCE_EN
    localparam bit DBE = 1'b1;
`else
    localparam bit DBE = 1'b0;
`endif
    localparam int L    = DBE ? 2 + int'(DB) : 2;
    localparam int MAXE = 16384;

    logic       clk = 1'b0;
    logic       rst_n, set_req, clr_req;
    logic       s, r, busy, conflict;
    logic [7:0] cmd_cnt;

    always #5 clk = ~clk;

    sr_cmd_gen #(
        .DB_CYCLES  (DB),
        .GAP_CYCLES (GAP),
        .PRIO_SET   (PRIO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_req  (set_req),
        .clr_req  (clr_req),
        .s        (s),
        .r        (r),
        .busy     (busy),
        .conflict (conflict),
        .cmd_cnt  (cmd_cnt)
    );

    int checks = 0;
    int errors = 0;
    int e = 0;

    // raw request level seen at each clock edge (0 while in reset)
    bit raw_s[MAXE];
    bit raw_c[MAXE];

    // timeline model: pending requests, earliest next issue edge, last issue
    bit m_ps, m_pc, m_kind_s, m_conf;
    int m_ready, m_last, m_cnt;

    // observations of the DUT
    int n_s, n_r, n_conf, first_s, first_r, last_pulse;

    typedef struct {
        bit set_on;
        bit clr_on;
        int clr_dly;
        int exp_s;
        int exp_r;
        int exp_conf;
        int exp_gap;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, e, act, exp);
        end
    endtask

    // Filtered request level after edge t: debounced = all of the DB previous
    // synchronised samples high; otherwise just the synchronised sample.
    function automatic bit filt(input bit c, input int t);
        if (!DBE) begin
            if (t - 1 < 0) return 1'b0;
            return c ? raw_c[t-1] : raw_s[t-1];
        end
        for (int k = t - 1 - int'(DB); k <= t - 2; k++) begin
            if (k < 0) return 1'b0;
            if (!(c ? raw_c[k] : raw_s[k])) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int gap_exp(input int dly);
        return (dly > 1 + int'(GAP)) ? dly : 1 + int'(GAP);
    endfunction

    task automatic clear_obs();
        n_s = 0; n_r = 0; n_conf = 0; first_s = -1; first_r = -1;
    endtask

    task automatic model_reset();
        m_ps = 1'b0; m_pc = 1'b0; m_kind_s = 1'b0; m_conf = 1'b0;
        m_ready = 0; m_last = -1000; m_cnt = 0; last_pulse = -1000;
        for (int k = 0; k <= e; k++) begin
            raw_s[k] = 1'b0;
            raw_c[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (filt(1'b0, e - 1) && !filt(1'b0, e - 2)) m_ps = 1'b1;
        if (filt(1'b1, e - 1) && !filt(1'b1, e - 2)) m_pc = 1'b1;
        if (e >= m_ready && (m_ps || m_pc)) begin
            m_conf   = m_ps && m_pc;
            m_kind_s = m_ps && (!m_pc || PRIO);
            m_last   = e;
            m_ready  = e + 1 + ((GAP == 0) ? 1 : int'(GAP));
            m_cnt    = (m_cnt + 1) % 256;
            m_ps     = 1'b0;
            m_pc     = 1'b0;
        end
    endtask

    task automatic compare();
        bit pulse_now;
        pulse_now = (m_last == e);
        check("s", s, pulse_now && m_kind_s);
        check("r", r, pulse_now && !m_kind_s);
        check("conflict", conflict, pulse_now && m_conf);
        check("busy", busy, (e >= m_last) && (e - m_last <= int'(GAP)));
        check("cmd_cnt", cmd_cnt, m_cnt);
        check("s_and_r", s & r, 1'b0);
        if (s === 1'b1 || r === 1'b1) begin
            if (last_pulse > -1000)
                check("spacing_ok", (e - last_pulse) >= 1 + int'(GAP), 1);
            last_pulse = e;
            if (s === 1'b1) begin n_s++; if (first_s < 0) first_s = e; end
            if (r === 1'b1) begin n_r++; if (first_r < 0) first_r = e; end
            if (conflict === 1'b1) n_conf++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        e++;
        if (!rst_n) begin
            model_reset();
        end else begin
            raw_s[e] = set_req;
            raw_c[e] = clr_req;
            model_edge();
        end
        #1;
        compare();
    endtask

    initial begin
        int raise_e, first_any, stable_e;

        rst_n = 1'b1; set_req = 1'b0; clr_req = 1'b0;
        model_reset();
        clear_obs();
        #2;

        // reset held with both requests high
        rst_n = 1'b0; set_req = 1'b1; clr_req = 1'b1;
        #1;
        check("reset_s", s, 1'b0);
        check("reset_cnt", cmd_cnt, 8'd0);
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b1;
        raise_e = e + 1;
        for (int i = 0; i < 25; i++) step();
        first_any = (first_s >= 0) ? first_s : first_r;
        check("post_reset_latency", first_any - raise_e, L);
        check("post_reset_conflict", n_conf, 1);
        set_req = 1'b0; clr_req = 1'b0;
        for (int i = 0; i < 15; i++) step();

        // scenario table
        tbl[0] = '{1'b1, 1'b0, 0, 1, 0, 0, -1};
        tbl[1] = '{1'b0, 1'b1, 0, 0, 1, 0, -1};
        tbl[2] = '{1'b1, 1'b1, 0, PRIO ? 1 : 0, PRIO ? 0 : 1, 1, -1};
        tbl[3] = '{1'b1, 1'b1, 1, 1, 1, 0, gap_exp(1)};
        tbl[4] = '{1'b1, 1'b1, 2, 1, 1, 0, gap_exp(2)};
        tbl[5] = '{1'b1, 1'b1, 5, 1, 1, 0, gap_exp(5)};
        for (int v = 0; v < 6; v++) begin
            clear_obs();
            raise_e = e + 1;
            set_req = tbl[v].set_on;
            for (int i = 0; i < 30; i++) begin
                if (tbl[v].clr_on && i == tbl[v].clr_dly) clr_req = 1'b1;
                step();
            end
            set_req = 1'b0; clr_req = 1'b0;
            for (int i = 0; i < 15; i++) step();
            check($sformatf("vec%0d_s_count", v), n_s, tbl[v].exp_s);
            check($sformatf("vec%0d_r_count", v), n_r, tbl[v].exp_r);
            check($sformatf("vec%0d_conflicts", v), n_conf, tbl[v].exp_conf);
            first_any = (first_s >= 0) ? first_s : first_r;
            check($sformatf("vec%0d_latency", v), first_any - raise_e, L);
            if (tbl[v].exp_gap >= 0)
                check($sformatf("vec%0d_s_to_r", v), first_r - first_s, tbl[v].exp_gap);
        end

        // bounce: toggle every 2 cycles for 20 cycles, then stable high
        clear_obs();
        for (int i = 0; i < 20; i++) begin
            set_req = ((i / 2) % 2) == 0;
            step();
        end
        stable_e = e + 1;
        set_req = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("bounce_pulses", n_s, DBE ? 1 : 6);
        if (DBE) check("bounce_latency", first_s - stable_e, L);
        set_req = 1'b0;
        for (int i = 0; i < 15; i++) step();

        // counter wrap after 256 pulses from reset
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        clear_obs();
        for (int p = 0; p < 256; p++) begin
            set_req = 1'b1;
            for (int i = 0; i < int'(DB) + 2; i++) step();
            set_req = 1'b0;
            step(); step();
        end
        for (int i = 0; i < 10; i++) step();
        check("wrap_pulses", n_s, 256);
        check("wrap_cnt", cmd_cnt, 8'd0);

        // reset asserted during an s cycle
        set_req = 1'b1;
        for (int i = 0; i < 40 && s !== 1'b1; i++) step();
        check("wait_s_before_reset", s, 1'b1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midpulse_s_drop", s, 1'b0);
        check("midpulse_busy_drop", busy, 1'b0);
        check("midpulse_cnt", cmd_cnt, 8'd0);
        set_req = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b1;
        clear_obs();
        for (int i = 0; i < 20; i++) step();
        check("no_pulse_after_reset", n_s + n_r, 0);
        set_req = 1'b1;
        for (int i = 0; i < 15; i++) step();
        check("new_request_after_reset", n_s, 1);
        set_req = 1'b0;
        for (int i = 0; i < 10; i++) step();

        // random traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) set_req = ~set_req;
            if ($urandom_range(0, 5) == 0) clr_req = ~clr_req;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
